// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: RV32 ID-stage decoder, ID/EX control register and
// mul/div occupancy sequencer.
// Optional feature macro: RV32M_EN (M-extension decode plus sequencer).
// Without RV32M_EN, funct7=0000001 R-types decode as illegal and
// MdBusy/MdDone are tied low.
module ctrl_pipe_unit #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        MemtoRegE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        ALUSrcE,
  output logic [1:0]  ALUOpE,
  output logic [2:0]  ImmSrcE,
  output logic [2:0]  MdOpE,
  output logic        MdE,
  output logic        IllegalE,
  output logic        MdBusy,
  output logic        MdDone
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic [2:0] md_op;
    logic       md;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      dec;
  ctrl_t      ctrl_q;
  logic       md_hold;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  // Combinational decode of the ID-stage instruction
  always_comb begin
    dec = '0;
    case (opcode)
      7'b0000011: begin dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1; end
      7'b0100011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 3'b001; end
      7'b0110011: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.reg_write = 1'b1;
          dec.alu_op    = 2'b10;
        end
`ifdef RV32M_EN
        else if (funct7 == 7'b0000001) begin
          dec.reg_write = 1'b1;
          dec.alu_op    = 2'b10;
          dec.md        = 1'b1;
          dec.md_op     = funct3;
        end
`endif
        else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0010011: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b11; end
      7'b1100011: begin dec.branch = 1'b1; dec.alu_op = 2'b01; dec.imm_src = 3'b010; end
      7'b1101111: begin dec.jump = 1'b1; dec.reg_write = 1'b1; dec.imm_src = 3'b100; end
      7'b1100111: begin dec.jalr = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      7'b0110111,
      7'b0010111: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.imm_src = 3'b011; end
      7'b1110011: dec = '0;  // system ops execute as NOPs here
      default:    dec.illegal = 1'b1;
    endcase
  end

  // ID/EX control register: flush beats stall, and an occupied mul/div unit freezes it
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else if (!md_hold) begin
      if (FlushE || (!StallE && !ValidD)) ctrl_q <= '0;
      else if (!StallE)                   ctrl_q <= dec;
    end
  end

  assign RegWriteE = ctrl_q.reg_write;
  assign MemWriteE = ctrl_q.mem_write;
  assign MemtoRegE = ctrl_q.mem_to_reg;
  assign BranchE   = ctrl_q.branch;
  assign JumpE     = ctrl_q.jump;
  assign JalrE     = ctrl_q.jalr;
  assign ALUSrcE   = ctrl_q.alu_src;
  assign ALUOpE    = ctrl_q.alu_op;
  assign ImmSrcE   = ctrl_q.imm_src;
  assign MdOpE     = ctrl_q.md_op;
  assign MdE       = ctrl_q.md;
  assign IllegalE  = ctrl_q.illegal;

`ifdef RV32M_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [7:0] MUL_LAT = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAT = 8'(DIV_CYCLES - 1);

  md_state_t  md_state;
  logic [7:0] md_cnt;
  logic       load_m;

  assign md_hold = MdBusy;
  assign load_m  = !FlushE && !StallE && ValidD && dec.md;

  // Occupancy sequencer; a new M op loaded on the DONE cycle restarts BUSY
  // directly so back-to-back ops are not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= IDLE;
      md_cnt   <= 8'd0;
      MdBusy   <= 1'b0;
      MdDone   <= 1'b0;
    end else begin
      case (md_state)
        IDLE, DONE: begin
          MdDone <= 1'b0;
          if (load_m) begin
            md_state <= BUSY;
            md_cnt   <= funct3[2] ? DIV_LAT : MUL_LAT;
            MdBusy   <= 1'b1;
          end else begin
            md_state <= IDLE;
          end
        end
        BUSY: begin
          if (md_cnt == 8'd0) begin
            md_state <= DONE;
            MdBusy   <= 1'b0;
            MdDone   <= 1'b1;
          end else begin
            md_cnt <= md_cnt - 8'd1;
          end
        end
        default: begin
          md_state <= IDLE;
          MdBusy   <= 1'b0;
          MdDone   <= 1'b0;
        end
      endcase
    end
  end
`else
  assign md_hold = 1'b0;
  assign MdBusy  = 1'b0;
  assign MdDone  = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Testbench for ctrl_pipe_unit: directed scenarios plus randomized traffic
// checked against a behavioural model. Honours RV32M_EN like the DUT.
module tb_ctrl_pipe_unit;

  localparam int MUL_N = 3;
  localparam int DIV_N = 32;

  localparam logic [31:0] I_LW  = 32'h00012083;
  localparam logic [31:0] I_JAL = 32'h008000EF;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        ValidD, StallE, FlushE;
  logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, JumpE, JalrE, ALUSrcE;
  logic [1:0]  ALUOpE;
  logic [2:0]  ImmSrcE, MdOpE;
  logic        MdE, IllegalE, MdBusy, MdDone;
  logic [16:0] e_got;

  int n_checks = 0;
  int n_errors = 0;

  // model state: expected E vector, busy cycles still to come, done pulse
  logic [16:0] m_e;
  int          m_rem;
  logic        m_done;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
    .ALUOpE(ALUOpE), .ImmSrcE(ImmSrcE), .MdOpE(MdOpE), .MdE(MdE),
    .IllegalE(IllegalE), .MdBusy(MdBusy), .MdDone(MdDone)
  );

  assign e_got = {RegWriteE, MemWriteE, MemtoRegE, BranchE, JumpE, JalrE, ALUSrcE,
                  ALUOpE, ImmSrcE, MdOpE, MdE, IllegalE};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls from the instruction-class table.
  // Bit order: RegWrite MemWrite MemtoReg Branch Jump Jalr ALUSrc ALUOp ImmSrc MdOp Md Illegal
  function automatic logic [16:0] ref_dec(input logic [31:0] ins);
    logic [6:0] op;
    logic [6:0] f7;
    op = ins[6:0];
    f7 = ins[31:25];
    case (op)
      7'h03: return {7'b1010001, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0};
      7'h23: return {7'b0100001, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0};
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) return {7'b1000000, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0};
`ifdef RV32M_EN
        if (f7 == 7'h01) return {7'b1000000, 2'b10, 3'b000, ins[14:12], 1'b1, 1'b0};
`endif
        return 17'h1;
      end
      7'h13: return {7'b1000001, 2'b11, 3'b000, 3'b000, 1'b0, 1'b0};
      7'h63: return {7'b0001000, 2'b01, 3'b010, 3'b000, 1'b0, 1'b0};
      7'h6F: return {7'b1000100, 2'b00, 3'b100, 3'b000, 1'b0, 1'b0};
      7'h67: return {7'b1000011, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0};
      7'h37, 7'h17: return {7'b1000001, 2'b00, 3'b011, 3'b000, 1'b0, 1'b0};
      7'h73: return 17'h0;
      default: return 17'h1;
    endcase
  endfunction

  task automatic model_edge();
    logic [16:0] d;
    logic        busy_now;
    logic        loads;
    if (reset) begin
      m_e = '0; m_rem = 0; m_done = 1'b0;
    end else begin
      d        = ref_dec(InstrD);
      busy_now = (m_rem > 0);
      loads    = !busy_now && !FlushE && !StallE && ValidD;
      if (!busy_now) begin
        if (FlushE || (!StallE && !ValidD)) m_e = '0;
        else if (!StallE)                   m_e = d;
      end
      m_done = (m_rem == 1);
      if (m_rem > 0) m_rem = m_rem - 1;
      if (loads && d[1]) m_rem = InstrD[14] ? DIV_N : MUL_N;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("e_vec", {15'd0, e_got}, {15'd0, m_e});
    chk("md_busy", {31'd0, MdBusy}, {31'd0, (m_rem > 0)});
    chk("md_done", {31'd0, MdDone}, {31'd0, m_done});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [14];
    logic [6:0]  f7;
    logic [31:0] r;
    ops = '{7'h03, 7'h23, 7'h33, 7'h33, 7'h33, 7'h13, 7'h63,
            7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h00, 7'h7F};
    r = $urandom;
    case ($urandom_range(3, 0))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, r[24:7], ops[$urandom_range(13, 0)]};
  endfunction

  initial begin
    logic [16:0] held;
    int n;
    m_e = '0; m_rem = 0; m_done = 1'b0;
    reset = 1'b1; InstrD = '0; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    step(); step();
    chk("reset_e", {15'd0, e_got}, 32'd0);

    // a few random cycles, then a single reset cycle
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 InstrD = rand_instr(); ValidD = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    chk("rst_e", {15'd0, e_got}, 32'd0);
    chk("rst_busy", {31'd0, MdBusy}, 32'd0);
    chk("rst_done", {31'd0, MdDone}, 32'd0);
    reset = 1'b0;

    // decode sweep
    InstrD = I_LW; ValidD = 1'b1;
    step();
    chk("lw_regwrite", {31'd0, RegWriteE}, 32'd1);
    chk("lw_memtoreg", {31'd0, MemtoRegE}, 32'd1);
    chk("lw_alusrc", {31'd0, ALUSrcE}, 32'd1);
    chk("lw_immsrc", {29'd0, ImmSrcE}, 32'd0);
    chk("lw_memwrite", {31'd0, MemWriteE}, 32'd0);
    InstrD = I_JAL;
    step();
    chk("jal_jump", {31'd0, JumpE}, 32'd1);
    chk("jal_immsrc", {29'd0, ImmSrcE}, 32'd4);

    // stall holds, flush wins over stall
    InstrD = I_LW;
    step();
    held = ref_dec(I_LW);
    StallE = 1'b1; InstrD = I_JAL;
    step();
    chk("stall_hold1", {15'd0, e_got}, {15'd0, held});
    step();
    chk("stall_hold2", {15'd0, e_got}, {15'd0, held});
    FlushE = 1'b1;
    step();
    chk("flush_over_stall", {15'd0, e_got}, 32'd0);
    StallE = 1'b0; FlushE = 1'b0;

`ifdef RV32M_EN
    // multiply: 3 busy cycles, done on the 4th, then idle
    InstrD = I_MUL; ValidD = 1'b1;
    step();
    ValidD = 1'b0;
    for (int i = 0; i < MUL_N; i++) begin
      chk("mul_busy", {31'd0, MdBusy}, 32'd1);
      chk("mul_no_done", {31'd0, MdDone}, 32'd0);
      step();
    end
    chk("mul_done", {31'd0, MdDone}, 32'd1);
    chk("mul_done_busy", {31'd0, MdBusy}, 32'd0);
    step();
    chk("mul_idle", {30'd0, MdDone, MdBusy}, 32'd0);

    // divide with a flush in the middle of BUSY
    InstrD = I_DIV; ValidD = 1'b1;
    step();
    ValidD = 1'b0;
    n = 0;
    while (!MdDone && n < 60) begin
      FlushE = (n == 10 || n == 11);
      step();
      n++;
    end
    FlushE = 1'b0;
    chk("div_latency", n, DIV_N);

    // reset in the middle of a divide
    InstrD = I_DIV; ValidD = 1'b1;
    step();
    ValidD = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    chk("div_rst_busy", {31'd0, MdBusy}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("div_rst_idle", {30'd0, MdDone, MdBusy}, 32'd0);
`else
    InstrD = I_MUL; ValidD = 1'b1;
    step();
    ValidD = 1'b0;
    chk("mul_illegal", {31'd0, IllegalE}, 32'd1);
    chk("mul_md", {31'd0, MdE}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mul_no_busy", {31'd0, MdBusy}, 32'd0);
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      InstrD = rand_instr();
      ValidD = ($urandom_range(7, 0) != 0);
      StallE = ($urandom_range(5, 0) == 0);
      FlushE = ($urandom_range(9, 0) == 0);
      reset  = ($urandom_range(96, 0) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
